// File: rtl/operand_fwd_stage_pkg.sv
// Shared select encodings and constants for the decode/execute operand stage.
package operand_fwd_stage_pkg;

    typedef enum logic [1:0] {
        ALU_OP_A_SEL_REG  = 2'd0,
        ALU_OP_A_SEL_PC   = 2'd1,
        ALU_OP_A_SEL_IMM  = 2'd2,
        ALU_OP_A_SEL_ZERO = 2'd3
    } alu_op_a_sel_e;

    typedef enum logic [1:0] {
        ALU_OP_B_SEL_REG  = 2'd0,
        ALU_OP_B_SEL_IMM  = 2'd1,
        ALU_OP_B_SEL_FOUR = 2'd2,
        ALU_OP_B_SEL_ZERO = 2'd3
    } alu_op_b_sel_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'd0,
        WB_SEL_PCPLUS4 = 2'd1,
        WB_SEL_LOAD    = 2'd2,
        WB_SEL_IMM     = 2'd3
    } wb_sel_e;

    localparam int OPERAND_FOUR = 4;

endpackage

// File: rtl/operand_fwd_stage_fwd_mux.sv
// Per-source bypass selection: unused/x0 read as zero, then EX/MEM, then MEM/WB, then the register file.
module operand_fwd_stage_fwd_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      rs_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic                      exm_we_i,
    input  logic                      exm_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
    input  logic [DATA_WIDTH-1:0]     exm_result_i,
    input  logic                      mwb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_i,
    input  logic [DATA_WIDTH-1:0]     mwb_data_i,
    input  logic [DATA_WIDTH-1:0]     rf_data_i,
    output logic [DATA_WIDTH-1:0]     fwd_data_o
);

    always_comb begin
        fwd_data_o = rf_data_i;
        if (!rs_valid_i || rs_i == '0) begin
            fwd_data_o = '0;
        // A load's EX/MEM value is only an address; the hazard logic stalls instead.
        end else if (exm_we_i && !exm_is_load_i && exm_rd_i == rs_i) begin
            fwd_data_o = exm_result_i;
        end else if (mwb_we_i && mwb_rd_i == rs_i) begin
            fwd_data_o = mwb_data_i;
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// Decode/execute operand register with EX/MEM and MEM/WB bypass, load-use bubble insertion and writeback mux.
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [1:0]                alu_op_a_sel_i,
    input  logic [1:0]                alu_op_b_sel_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
    input  logic                      rs1_valid_i,
    input  logic                      rs2_valid_i,
    input  logic [ADDR_WIDTH-1:0]     imm_i,
    input  logic [ADDR_WIDTH-1:0]     pc_i,
    input  logic [DATA_WIDTH-1:0]     rf_rp_a_i,
    input  logic [DATA_WIDTH-1:0]     rf_rp_b_i,
    input  logic                      exm_we_i,
    input  logic                      exm_is_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] exm_rd_i,
    input  logic [DATA_WIDTH-1:0]     exm_result_i,
    input  logic                      mwb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] mwb_rd_i,
    input  logic [DATA_WIDTH-1:0]     mwb_data_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_WIDTH-1:0]     alu_op_a_o,
    output logic [DATA_WIDTH-1:0]     alu_op_b_o,
    input  logic [1:0]                wb_sel_i,
    input  logic [DATA_WIDTH-1:0]     wb_alu_i,
    input  logic [DATA_WIDTH-1:0]     wb_pcplus4_i,
    input  logic [DATA_WIDTH-1:0]     wb_load_i,
    input  logic [DATA_WIDTH-1:0]     wb_imm_i,
    output logic [DATA_WIDTH-1:0]     rf_wd_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    logic                  hz;
    logic                  adv;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] op_a_next;
    logic [DATA_WIDTH-1:0] op_b_next;

    operand_fwd_stage_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_a (
        .rs_valid_i   (rs1_valid_i),
        .rs_i         (rs1_i),
        .exm_we_i     (exm_we_i),
        .exm_is_load_i(exm_is_load_i),
        .exm_rd_i     (exm_rd_i),
        .exm_result_i (exm_result_i),
        .mwb_we_i     (mwb_we_i),
        .mwb_rd_i     (mwb_rd_i),
        .mwb_data_i   (mwb_data_i),
        .rf_data_i    (rf_rp_a_i),
        .fwd_data_o   (fwd_a)
    );

    operand_fwd_stage_fwd_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_b (
        .rs_valid_i   (rs2_valid_i),
        .rs_i         (rs2_i),
        .exm_we_i     (exm_we_i),
        .exm_is_load_i(exm_is_load_i),
        .exm_rd_i     (exm_rd_i),
        .exm_result_i (exm_result_i),
        .mwb_we_i     (mwb_we_i),
        .mwb_rd_i     (mwb_rd_i),
        .mwb_data_i   (mwb_data_i),
        .rf_data_i    (rf_rp_b_i),
        .fwd_data_o   (fwd_b)
    );

    // Load-use hazard is gated only by source-used flags, not by the operand selects.
    assign hz = in_valid_i && exm_we_i && exm_is_load_i && (exm_rd_i != '0) &&
                ((rs1_valid_i && rs1_i == exm_rd_i) || (rs2_valid_i && rs2_i == exm_rd_i));

    // Handshake: a transfer happens on a cycle where valid and ready are both high; the
    // output register advances when empty or drained, and ready never depends on flush.
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv && !hz;

    always_comb begin
        op_a_next = '0;
        case (alu_op_a_sel_e'(alu_op_a_sel_i))
            ALU_OP_A_SEL_REG:  op_a_next = fwd_a;
            ALU_OP_A_SEL_PC:   op_a_next = DATA_WIDTH'(pc_i);
            ALU_OP_A_SEL_IMM:  op_a_next = DATA_WIDTH'(imm_i);
            ALU_OP_A_SEL_ZERO: op_a_next = '0;
        endcase
    end

    always_comb begin
        op_b_next = '0;
        case (alu_op_b_sel_e'(alu_op_b_sel_i))
            ALU_OP_B_SEL_REG:  op_b_next = fwd_b;
            ALU_OP_B_SEL_IMM:  op_b_next = DATA_WIDTH'(imm_i);
            ALU_OP_B_SEL_FOUR: op_b_next = DATA_WIDTH'(OPERAND_FOUR);
            ALU_OP_B_SEL_ZERO: op_b_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            alu_op_a_o  <= '0;
            alu_op_b_o  <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (adv) begin
            out_valid_o <= in_valid_i && !hz;
            if (in_valid_i && !hz) begin
                alu_op_a_o <= op_a_next;
                alu_op_b_o <= op_b_next;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (adv && hz && !flush_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    always_comb begin
        rf_wd_o = wb_alu_i;
        case (wb_sel_e'(wb_sel_i))
            WB_SEL_ALU:     rf_wd_o = wb_alu_i;
            WB_SEL_PCPLUS4: rf_wd_o = wb_pcplus4_i;
            WB_SEL_LOAD:    rf_wd_o = wb_load_i;
            WB_SEL_IMM:     rf_wd_o = wb_imm_i;
        endcase
    end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed and randomized checks of operand_fwd_stage against a behavioural pipeline model.
module tb_operand_fwd_stage;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i, in_ready_o;
  logic [1:0]    alu_op_a_sel_i, alu_op_b_sel_i;
  logic [RW-1:0] rs1_i, rs2_i;
  logic          rs1_valid_i, rs2_valid_i;
  logic [AW-1:0] imm_i, pc_i;
  logic [DW-1:0] rf_rp_a_i, rf_rp_b_i;
  logic          exm_we_i, exm_is_load_i;
  logic [RW-1:0] exm_rd_i;
  logic [DW-1:0] exm_result_i;
  logic          mwb_we_i;
  logic [RW-1:0] mwb_rd_i;
  logic [DW-1:0] mwb_data_i;
  logic          flush_i;
  logic          out_valid_o, out_ready_i;
  logic [DW-1:0] alu_op_a_o, alu_op_b_o;
  logic [1:0]    wb_sel_i;
  logic [DW-1:0] wb_alu_i, wb_pcplus4_i, wb_load_i, wb_imm_i;
  logic [DW-1:0] rf_wd_o;
  logic [CW-1:0] stall_cnt_o;

  operand_fwd_stage #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_a_sel_i(alu_op_a_sel_i), .alu_op_b_sel_i(alu_op_b_sel_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_valid_i(rs1_valid_i), .rs2_valid_i(rs2_valid_i),
    .imm_i(imm_i), .pc_i(pc_i), .rf_rp_a_i(rf_rp_a_i), .rf_rp_b_i(rf_rp_b_i),
    .exm_we_i(exm_we_i), .exm_is_load_i(exm_is_load_i), .exm_rd_i(exm_rd_i),
    .exm_result_i(exm_result_i),
    .mwb_we_i(mwb_we_i), .mwb_rd_i(mwb_rd_i), .mwb_data_i(mwb_data_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
    .wb_sel_i(wb_sel_i), .wb_alu_i(wb_alu_i), .wb_pcplus4_i(wb_pcplus4_i),
    .wb_load_i(wb_load_i), .wb_imm_i(wb_imm_i),
    .rf_wd_o(rf_wd_o), .stall_cnt_o(stall_cnt_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // behavioural model state
  logic          m_valid;
  logic [DW-1:0] m_a, m_b;
  int unsigned   m_cnt;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model_src(input logic v, input logic [RW-1:0] idx,
                                              input logic [DW-1:0] rf);
    if (!v || idx == 0) return '0;
    if (exm_we_i && !exm_is_load_i && exm_rd_i == idx) return exm_result_i;
    if (mwb_we_i && mwb_rd_i == idx) return mwb_data_i;
    return rf;
  endfunction

  function automatic logic model_hz();
    logic uses_load;
    uses_load = (rs1_valid_i && rs1_i == exm_rd_i) || (rs2_valid_i && rs2_i == exm_rd_i);
    return in_valid_i && exm_we_i && exm_is_load_i && exm_rd_i != 0 && uses_load;
  endfunction

  function automatic logic [DW-1:0] model_wd();
    logic [DW-1:0] srcs [4];
    srcs[0] = wb_alu_i;
    srcs[1] = wb_pcplus4_i;
    srcs[2] = wb_load_i;
    srcs[3] = wb_imm_i;
    return srcs[wb_sel_i];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_a = '0;
    m_b = '0;
    m_cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, m_valid});
    check({tag, ".op_a"}, alu_op_a_o, m_a);
    check({tag, ".op_b"}, alu_op_b_o, m_b);
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt_o}, m_cnt[DW-1:0]);
  endtask

  task automatic idle_inputs();
    in_valid_i = 0; alu_op_a_sel_i = 0; alu_op_b_sel_i = 0;
    rs1_i = 0; rs2_i = 0; rs1_valid_i = 0; rs2_valid_i = 0;
    imm_i = 0; pc_i = 0; rf_rp_a_i = 0; rf_rp_b_i = 0;
    exm_we_i = 0; exm_is_load_i = 0; exm_rd_i = 0; exm_result_i = 0;
    mwb_we_i = 0; mwb_rd_i = 0; mwb_data_i = 0;
    flush_i = 0; out_ready_i = 1; wb_sel_i = 0;
    wb_alu_i = 32'hA1; wb_pcplus4_i = 32'hB2; wb_load_i = 32'hC3; wb_imm_i = 32'hD4;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle(input string tag);
    logic          hz, adv, ld;
    logic [DW-1:0] na, nb;
    #1;
    hz  = model_hz();
    adv = !m_valid || out_ready_i;
    check({tag, ".in_ready"}, {31'd0, in_ready_o}, {31'd0, adv && !hz});
    check({tag, ".rf_wd"}, rf_wd_o, model_wd());
    case (alu_op_a_sel_i)
      2'd0: na = model_src(rs1_valid_i, rs1_i, rf_rp_a_i);
      2'd1: na = {16'd0, pc_i};
      2'd2: na = {16'd0, imm_i};
      default: na = '0;
    endcase
    case (alu_op_b_sel_i)
      2'd0: nb = model_src(rs2_valid_i, rs2_i, rf_rp_b_i);
      2'd1: nb = {16'd0, imm_i};
      2'd2: nb = 32'd4;
      default: nb = '0;
    endcase
    ld = in_valid_i && !hz;
    @(posedge clk_i);
    #1;
    if (flush_i) begin
      m_valid = 1'b0;
    end else if (adv) begin
      m_valid = ld;
      if (ld) begin
        m_a = na;
        m_b = nb;
      end
    end
    if (adv && hz && !flush_i && m_cnt < CNT_MAX) m_cnt++;
    check_regs(tag);
    @(negedge clk_i);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_i = 1;
    #3;
    check_regs("reset");
    @(negedge clk_i);
    rst_i = 0;

    // bypass priority: EX/MEM over MEM/WB over register file, x0 reads zero
    in_valid_i = 1; rs1_valid_i = 1; rs1_i = 5; rf_rp_a_i = 32'h11;
    exm_we_i = 1; exm_rd_i = 5; exm_result_i = 32'hAA;
    mwb_we_i = 1; mwb_rd_i = 5; mwb_data_i = 32'hBB;
    cycle("fwd_exm");
    check("fwd_exm.const", alu_op_a_o, 32'hAA);
    exm_we_i = 0;
    cycle("fwd_mwb");
    check("fwd_mwb.const", alu_op_a_o, 32'hBB);
    rs1_i = 0;
    cycle("fwd_x0");
    check("fwd_x0.const", alu_op_a_o, 32'h0);

    // load-use hazard: one bubble, then bypass from MEM/WB
    idle_inputs();
    in_valid_i = 1; rs2_valid_i = 1; rs2_i = 7; rf_rp_b_i = 32'h55;
    exm_we_i = 1; exm_is_load_i = 1; exm_rd_i = 7; exm_result_i = 32'h9999;
    cycle("hz");
    check("hz.bubble", {31'd0, out_valid_o}, 32'd0);
    check("hz.cnt_one", {28'd0, stall_cnt_o}, 32'd1);
    exm_we_i = 0; exm_is_load_i = 0;
    mwb_we_i = 1; mwb_rd_i = 7; mwb_data_i = 32'h1234;
    cycle("hz_after");
    check("hz_after.const", alu_op_b_o, 32'h1234);

    // output back-pressure holds operands and blocks input
    idle_inputs();
    in_valid_i = 1; alu_op_a_sel_i = 2; imm_i = 16'h0777;
    cycle("bp_fill");
    out_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      imm_i = AW'($urandom_range(0, 65535));
      cycle("bp_hold");
      check("bp_hold.const", alu_op_a_o, 32'h777);
    end
    out_ready_i = 1; imm_i = 16'h0888;
    cycle("bp_release");
    check("bp_release.const", alu_op_a_o, 32'h888);

    // flush wins over a simultaneous accept
    flush_i = 1; imm_i = 16'h0999;
    cycle("flush");
    check("flush.const", {31'd0, out_valid_o}, 32'd0);
    flush_i = 0;

    // PC / FOUR operands and all writeback sources
    idle_inputs();
    in_valid_i = 1; alu_op_a_sel_i = 1; alu_op_b_sel_i = 2; pc_i = 16'h0100;
    for (int s = 0; s < 4; s++) begin
      wb_sel_i = 2'(s);
      cycle("pc_four");
      check("pc_four.a", alu_op_a_o, 32'h100);
      check("pc_four.b", alu_op_b_o, 32'h4);
    end

    // continuous hazard drives the counter into saturation
    idle_inputs();
    in_valid_i = 1; rs1_valid_i = 1; rs1_i = 3;
    exm_we_i = 1; exm_is_load_i = 1; exm_rd_i = 3;
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat.const", {28'd0, stall_cnt_o}, 32'hF);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid_i     = ($urandom_range(0, 9) < 8);
      alu_op_a_sel_i = 2'($urandom_range(0, 3));
      alu_op_b_sel_i = 2'($urandom_range(0, 3));
      rs1_i = RW'($urandom_range(0, 7));  rs2_i = RW'($urandom_range(0, 7));
      rs1_valid_i = 1'($urandom);         rs2_valid_i = 1'($urandom);
      imm_i = AW'($urandom);              pc_i = AW'($urandom);
      rf_rp_a_i = $urandom;               rf_rp_b_i = $urandom;
      exm_we_i = 1'($urandom);            exm_is_load_i = ($urandom_range(0, 3) == 0);
      exm_rd_i = RW'($urandom_range(0, 7)); exm_result_i = $urandom;
      mwb_we_i = 1'($urandom);            mwb_rd_i = RW'($urandom_range(0, 7));
      mwb_data_i = $urandom;
      flush_i = ($urandom_range(0, 15) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      wb_sel_i = 2'($urandom_range(0, 3));
      wb_alu_i = $urandom; wb_pcplus4_i = $urandom; wb_load_i = $urandom; wb_imm_i = $urandom;
      cycle("rand");
    end

    // asynchronous reset mid-stream with a valid output
    idle_inputs();
    in_valid_i = 1; alu_op_a_sel_i = 2; alu_op_b_sel_i = 1; imm_i = 16'h4321;
    cycle("pre_rst");
    check("pre_rst.valid", {31'd0, out_valid_o}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_i = 1;
    #1;
    model_reset();
    check_regs("async_rst");
    @(negedge clk_i);
    rst_i = 0;
    idle_inputs();
    cycle("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/operand_fwd_stage.md
Name: operand_fwd_stage

Overview:
Parametrised, pipelined successor to the purely combinational operand/writeback glue logic. It sits between decode and the ALU, and registers ALU operands in a decode/execute pipeline register. It forwards results from the EX/MEM and MEM/WB stages, detects load-use hazards, and inserts one bubble per hazard. It uses a valid/ready handshake and supports flush. The writeback data mux is extended to four sources.

Parameters:
DATA_WIDTH, 32, datapath width of operands, results and writeback data
ADDR_WIDTH, 32, PC and immediate width; must be <= DATA_WIDTH (zero-extended if smaller)
REG_ADDR_WIDTH, 5, register index width; index 0 is hard-wired zero
CNT_WIDTH, 16, width of the saturating stall counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  decoded instruction present
in_ready_o  out  1  stage accepts instruction this cycle
alu_op_a_sel_i  in  2  0 REG, 1 PC, 2 IMM, 3 ZERO
alu_op_b_sel_i  in  2  0 REG, 1 IMM, 2 FOUR, 3 ZERO
rs1_i / rs2_i  in  REG_ADDR_WIDTH  source register indices
rs1_valid_i / rs2_valid_i  in  1  source register is used
imm_i  in  ADDR_WIDTH  immediate
pc_i  in  ADDR_WIDTH  instruction PC
rf_rp_a_i / rf_rp_b_i  in  DATA_WIDTH  register file read data
exm_we_i  in  1  EX/MEM writes rd
exm_is_load_i  in  1  EX/MEM instruction is a load
exm_rd_i  in  REG_ADDR_WIDTH  EX/MEM destination
exm_result_i  in  DATA_WIDTH  EX/MEM ALU result
mwb_we_i  in  1  MEM/WB writes rd
mwb_rd_i  in  REG_ADDR_WIDTH  MEM/WB destination
mwb_data_i  in  DATA_WIDTH  MEM/WB final writeback data
flush_i  in  1  kill the instruction held in the stage
out_valid_o  out  1  registered operands valid
out_ready_i  in  1  execute stage accepts
alu_op_a_o / alu_op_b_o  out  DATA_WIDTH  registered ALU operands
wb_sel_i  in  2  0 ALU, 1 PC+4, 2 LOAD, 3 IMM
wb_alu_i / wb_pcplus4_i / wb_load_i / wb_imm_i  in  DATA_WIDTH  writeback sources
rf_wd_o  out  DATA_WIDTH  writeback data (combinational)
stall_cnt_o  out  CNT_WIDTH  saturating count of load-use bubbles

Behaviour:
- Reset (async, active-high): out_valid_o=0, alu_op_a_o=0, alu_op_b_o=0, stall_cnt_o=0.
- Forwarding, per source (rsN, N=1,2); priority is highest first:
  - if !rsN_valid_i: 0.
  - else if rsN_i==0: 0.
  - else if exm_we_i && !exm_is_load_i && exm_rd_i==rsN_i: exm_result_i.
  - else if mwb_we_i && mwb_rd_i==rsN_i: mwb_data_i.
  - else: rf_rp_{a,b}_i.
- Operand A: REG uses the forwarded rs1 value; PC uses zero-extended pc_i; IMM uses zero-extended imm_i; ZERO uses 0.
- Operand B: REG uses the forwarded rs2 value; IMM uses imm_i; FOUR uses 4; ZERO uses 0.
- Hazard: hz = in_valid_i && exm_we_i && exm_is_load_i && exm_rd_i!=0 && ((rs1_valid_i && rs1_i==exm_rd_i) || (rs2_valid_i && rs2_i==exm_rd_i)).
  - Only rsN_valid_i gates the hazard; the operand select is ignored.
- Handshake: adv = !out_valid_o || out_ready_i; in_ready_o = adv && !hz.
- Register update each clock, in priority order:
  1. flush_i: out_valid_o<=0, operands unchanged.
  2. else if adv: out_valid_o<=in_valid_i && !hz; operands load only when in_valid_i && !hz.
  3. else: hold all.
- Hazard latency: the hazard produces exactly one bubble. The next cycle the load sits in MEM/WB and is forwarded via mwb_data_i.
- Hazard while the output is stalled (!adv): no bubble is counted and no state changes.
- stall_cnt_o increments when adv && hz && !flush_i, and saturates at all-ones.
- Latency: 1 cycle from accept (in_valid_i && in_ready_o) to out_valid_o.
- Flush takes priority over a simultaneous accept; in_ready_o is not gated by flush.
- rf_wd_o: combinational 4:1 mux on wb_sel_i, with no default beyond the four codes.

Decomposition:
- Package: ALU_OP_A_SEL_* / ALU_OP_B_SEL_* / WB_SEL_* enum typedefs (2-bit) and the constant OPERAND_FOUR.
- Sub-module fwd_mux: one instance per source; implements valid/x0/EX/MEM/WB priority. Pure combinational.
- Pipeline register, hazard logic and counter live in the top module.

Test Plan:
1. Reset mid-stream with out_valid_o=1 -> out_valid_o, operands and stall_cnt_o are 0 asynchronously, before the next edge.
2. rs1=5, rf_rp_a_i=0x11, exm_we=1 exm_rd=5 exm_result=0xAA, mwb_rd=5 mwb_data=0xBB, sel REG -> alu_op_a_o=0xAA the next cycle. With exm_we=0 -> 0xBB. With rs1=0 -> 0.
3. Load in EX/MEM, rd=7; instruction has rs2=7 -> in_ready_o=0 for 1 cycle, out_valid_o=0 for 1 cycle, stall_cnt_o=1. Next cycle mwb_rd=7 mwb_data=0x1234 -> alu_op_b_o=0x1234.
4. out_ready_i=0 for 3 cycles with out_valid_o=1 -> operands held, in_ready_o=0. Release -> next instruction loads.
5. flush_i=1 together with an accepted instruction -> out_valid_o=0 the next cycle.
6. sel A=PC pc=0x100, B=FOUR; wb_sel=1,2,3 -> alu_op_a/b = 0x100/4, and rf_wd_o tracks the selected source each cycle. Stall counter forced to saturation -> it holds at all-ones.
